// File: rtl/stopwatch_counter.sv
// mm:ss BCD stopwatch core: prescaled 1 Hz tick, four BCD digits 00:00..59:59,
// start/stop, clear and lap controls with a one-cycle save pulse for lap storage.
module stopwatch_counter #(
  parameter int SIZE     = 4,
  parameter int TICK_DIV = 50000000,
  parameter int DIV_W    = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_stop,
  input  logic            clear,
  input  logic            lap,
  output logic [SIZE-1:0] units_second,
  output logic [SIZE-1:0] tens_second,
  output logic [SIZE-1:0] units_minute,
  output logic [SIZE-1:0] tens_minute,
  output logic            save,
  output logic            running,
  output logic            wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [SIZE-1:0]  D9        = SIZE'(9);
  localparam logic [SIZE-1:0]  D5        = SIZE'(5);

  state_t          state, state_nxt;
  logic            start_prev, clear_prev, lap_prev;
  logic            start_edge, clear_edge, lap_edge;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic            tick;
  logic [SIZE-1:0] us_nxt, ts_nxt, um_nxt, tm_nxt;
  logic            wrap_nxt, save_nxt;

  // Rising-edge detection against last cycle's button level.
  always_comb begin
    start_edge = start_stop & ~start_prev;
    clear_edge = clear & ~clear_prev;
    lap_edge   = lap & ~lap_prev;
  end

  // Next state and prescaler; clear outranks start_stop, and the RUN->PAUSE
  // cycle itself neither advances the prescaler nor ticks.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    tick      = 1'b0;
    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (start_edge) state_nxt = RUN;
      end
      RUN: begin
        if (clear_edge) begin
          state_nxt = IDLE;
          presc_nxt = '0;
        end else if (start_edge) begin
          state_nxt = PAUSE;
        end else if (presc >= PRESC_MAX) begin
          presc_nxt = '0;
          tick      = 1'b1;
        end else begin
          presc_nxt = presc + DIV_W'(1);
        end
      end
      PAUSE: begin
        if (clear_edge) begin
          state_nxt = IDLE;
          presc_nxt = '0;
        end else if (start_edge) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        presc_nxt = '0;
      end
    endcase
  end

  // BCD carry chain; >= comparisons pull any out-of-range digit back to zero.
  always_comb begin
    us_nxt   = units_second;
    ts_nxt   = tens_second;
    um_nxt   = units_minute;
    tm_nxt   = tens_minute;
    wrap_nxt = 1'b0;
    if (state_nxt == IDLE) begin
      us_nxt = '0;
      ts_nxt = '0;
      um_nxt = '0;
      tm_nxt = '0;
    end else if (tick) begin
      if (units_second < D9) begin
        us_nxt = units_second + SIZE'(1);
      end else begin
        us_nxt = '0;
        if (tens_second < D5) begin
          ts_nxt = tens_second + SIZE'(1);
        end else begin
          ts_nxt = '0;
          if (units_minute < D9) begin
            um_nxt = units_minute + SIZE'(1);
          end else begin
            um_nxt = '0;
            if (tens_minute < D5) begin
              tm_nxt = tens_minute + SIZE'(1);
            end else begin
              tm_nxt   = '0;
              wrap_nxt = 1'b1;
            end
          end
        end
      end
    end
  end

  // Lap save is only honoured while a time is being shown and no clear is pending.
  always_comb begin
    save_nxt = lap_edge & ((state == RUN) | (state == PAUSE)) & ~clear_edge;
  end

  // All state, counters, pulses and edge history registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      presc        <= '0;
      units_second <= '0;
      tens_second  <= '0;
      units_minute <= '0;
      tens_minute  <= '0;
      save         <= 1'b0;
      wrap         <= 1'b0;
      running      <= 1'b0;
      start_prev   <= 1'b0;
      clear_prev   <= 1'b0;
      lap_prev     <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      units_second <= us_nxt;
      tens_second  <= ts_nxt;
      units_minute <= um_nxt;
      tens_minute  <= tm_nxt;
      save         <= save_nxt;
      wrap         <= wrap_nxt;
      running      <= (state_nxt == RUN);
      start_prev   <= start_stop;
      clear_prev   <= clear;
      lap_prev     <= lap;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter with a 4-cycle tick; expected snapshots are
// queued as stimulus is applied and popped when the DUT output is sampled.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] units_second, tens_second, units_minute, tens_minute;
  logic       save, running, wrap;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [18:0] sb_q[$];
  logic [18:0] got, e;

  stopwatch_counter #(
    .SIZE(4),
    .TICK_DIV(4),
    .DIV_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(start_stop),
    .clear(clear),
    .lap(lap),
    .units_second(units_second),
    .tens_second(tens_second),
    .units_minute(units_minute),
    .tens_minute(tens_minute),
    .save(save),
    .running(running),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout need finish");
    $fatal(1, "watchdog expired");
  end

  // Packed snapshot: {tm, um, ts, us, running, save, wrap}
  function automatic logic [18:0] pk(input logic [15:0] d, input logic r,
                                     input logic s, input logic w);
    return {d, r, s, w};
  endfunction

  function automatic logic [18:0] obs();
    return {tens_minute, units_minute, tens_second, units_second, running, save, wrap};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    #2;
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_initial: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    start_stop = 1'b1;
    step(2);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_hold: got %h need %h", got, e); end
    start_stop = 1'b0;
    rst = 1'b1;
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    step(2);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL reset_release: got %h need %h", got, e); end
  endtask

  task automatic test_count();
    start_stop = 1'b1;
    sb_q.push_back(pk(16'h0000, 1'b1, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL count_start: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0010, 1'b1, 1'b0, 1'b0));
    step(40);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL count_40clk: got %h need %h", got, e); end
    clear = 1'b1;
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL count_clear: got %h need %h", got, e); end
    clear = 1'b0;
    start_stop = 1'b0;
    step(1);
  endtask

  task automatic test_wrap();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    sb_q.push_back(pk(16'h5958, 1'b1, 1'b0, 1'b0));
    step(14392);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL wrap_preload: got %h need %h", got, e); end
    for (int c = 1; c <= 9; c++) begin
      sb_q.push_back(pk((c < 4) ? 16'h5958 : (c < 8) ? 16'h5959 : 16'h0000,
                        1'b1, 1'b0, (c == 8) ? 1'b1 : 1'b0));
      step(1);
      got = obs(); e = sb_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL wrap_cycle%0d: got %h need %h", c, got, e); end
    end
    go_idle();
  endtask

  task automatic test_pause();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    sb_q.push_back(pk(16'h0001, 1'b1, 1'b0, 1'b0));
    step(6);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL pause_before: got %h need %h", got, e); end
    start_stop = 1'b1;
    sb_q.push_back(pk(16'h0001, 1'b0, 1'b0, 1'b0));
    step(1);
    start_stop = 1'b0;
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL pause_enter: got %h need %h", got, e); end
    for (int c = 1; c <= 20; c++) begin
      sb_q.push_back(pk(16'h0001, 1'b0, 1'b0, 1'b0));
      step(1);
      got = obs(); e = sb_q.pop_front(); n_cmp++;
      if (got !== e) begin n_bad++; $display("FAIL pause_frozen%0d: got %h need %h", c, got, e); end
    end
    start_stop = 1'b1;
    sb_q.push_back(pk(16'h0001, 1'b1, 1'b0, 1'b0));
    step(1);
    start_stop = 1'b0;
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL resume_edge: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0001, 1'b1, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL resume_plus1: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0002, 1'b1, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL resume_plus2: got %h need %h", got, e); end
    go_idle();
  endtask

  task automatic test_lap();
    int extra;
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    sb_q.push_back(pk(16'h0003, 1'b1, 1'b0, 1'b0));
    step(12);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL lap_pre: got %h need %h", got, e); end
    lap = 1'b1;
    sb_q.push_back(pk(16'h0003, 1'b1, 1'b1, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL lap_run_save: got %h need %h", got, e); end
    extra = 0;
    for (int c = 0; c < 9; c++) begin
      step(1);
      if (save === 1'b1) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL lap_held_extra: got %0d need 0", extra); end
    lap = 1'b0;
    go_idle();
    lap = 1'b1;
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL lap_idle: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL lap_idle_next: got %h need %h", got, e); end
    lap = 1'b0;
    step(1);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    step(5);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    lap = 1'b1;
    sb_q.push_back(pk(16'h0001, 1'b0, 1'b1, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL lap_pause_save: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0001, 1'b0, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL lap_pause_after: got %h need %h", got, e); end
    lap = 1'b0;
    go_idle();
  endtask

  task automatic test_clear_priority();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    sb_q.push_back(pk(16'h0007, 1'b1, 1'b0, 1'b0));
    step(28);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL clrprio_pre: got %h need %h", got, e); end
    clear = 1'b1;
    start_stop = 1'b1;
    lap = 1'b1;
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL clrprio_edge: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL clrprio_after: got %h need %h", got, e); end
    clear = 1'b0;
    start_stop = 1'b0;
    lap = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    sb_q.push_back(pk(16'h0005, 1'b1, 1'b0, 1'b0));
    step(23);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL rstmid_pre: got %h need %h", got, e); end
    rst = 1'b0;
    sb_q.push_back(pk(16'h0000, 1'b0, 1'b0, 1'b0));
    #1;
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL rstmid_async: got %h need %h", got, e); end
    step(1);
    rst = 1'b1;
    start_stop = 1'b1;
    sb_q.push_back(pk(16'h0000, 1'b1, 1'b0, 1'b0));
    step(1);
    start_stop = 1'b0;
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL rstmid_restart: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0000, 1'b1, 1'b0, 1'b0));
    step(3);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL rstmid_3clk: got %h need %h", got, e); end
    sb_q.push_back(pk(16'h0001, 1'b1, 1'b0, 1'b0));
    step(1);
    got = obs(); e = sb_q.pop_front(); n_cmp++;
    if (got !== e) begin n_bad++; $display("FAIL rstmid_4clk: got %h need %h", got, e); end
  endtask

  initial begin
    rst = 1'b0;
    start_stop = 1'b0;
    clear = 1'b0;
    lap = 1'b0;
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_lap();
    test_clear_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
